// File: rtl/lif_update_scheduler_if.sv
// Bundle of the scheduler's control, memory, shared-adder and spike-event signals.
// master = scheduler side, slave = environment (controller, memories, adder, spike sink).
interface lif_update_scheduler_if #(
    parameter int unsigned IDX_W = 5
);
    logic             start;
    logic             busy;
    logic             done;
    logic             mem_rd_en;
    logic [IDX_W-1:0] mem_addr;
    logic [31:0]      pot_rd_data;
    logic [31:0]      wgt_rd_data;
    logic             pot_wr_en;
    logic [31:0]      pot_wr_data;
    logic             wgt_wr_en;
    logic             set_adder;
    logic             clear_adder;
    logic [31:0]      adder_weight;
    logic [31:0]      adder_potential;
    logic [31:0]      adder_final;
    logic             adder_spike;
    logic             spike_valid;
    logic [IDX_W-1:0] spike_id;
    logic             spike_ready;
    logic [IDX_W:0]   spike_count;

    modport master (
        input  start, pot_rd_data, wgt_rd_data, adder_final, adder_spike, spike_ready,
        output busy, done, mem_rd_en, mem_addr, pot_wr_en, pot_wr_data, wgt_wr_en,
        output set_adder, clear_adder, adder_weight, adder_potential,
        output spike_valid, spike_id, spike_count
    );

    modport slave (
        output start, pot_rd_data, wgt_rd_data, adder_final, adder_spike, spike_ready,
        input  busy, done, mem_rd_en, mem_addr, pot_wr_en, pot_wr_data, wgt_wr_en,
        input  set_adder, clear_adder, adder_weight, adder_potential,
        input  spike_valid, spike_id, spike_count
    );
endinterface

// File: rtl/lif_update_scheduler.sv
// Sweeps all neurons through one shared LIF adder per timestep: read, evaluate, write back, spike.
// Optional macro SCHED_SKIP_ZERO_EN: neurons with a +/-0 weight bypass the adder evaluation.
module lif_update_scheduler #(
    parameter int unsigned NUM_NEURONS = 30,
    parameter int unsigned IDX_W       = 5,
    parameter int unsigned ADDER_LAT   = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    lif_update_scheduler_if.master bus
);
    typedef enum logic [2:0] {StIdle, StClr, StSet, StRd, StEval, StWb, StSpk, StFin} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_NEURONS - 1);
    localparam logic [3:0]       LastCnt = 4'(ADDER_LAT - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      pot_q, pot_d;
    logic [31:0]      wgt_q, wgt_d;
    logic [IDX_W:0]   scnt_q, scnt_d;
    logic             wb_spike;
    logic             advance;
`ifdef SCHED_SKIP_ZERO_EN
    logic             skip_q, skip_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            pot_q   <= '0;
            wgt_q   <= '0;
            scnt_q  <= '0;
`ifdef SCHED_SKIP_ZERO_EN
            skip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pot_q   <= pot_d;
            wgt_q   <= wgt_d;
            scnt_q  <= scnt_d;
`ifdef SCHED_SKIP_ZERO_EN
            skip_q  <= skip_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pot_d   = pot_q;
        wgt_d   = wgt_q;
        scnt_d  = scnt_q;
`ifdef SCHED_SKIP_ZERO_EN
        skip_d  = skip_q;
`endif
        wb_spike        = 1'b0;
        advance         = 1'b0;
        bus.done        = 1'b0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_addr    = '0;
        bus.pot_wr_en   = 1'b0;
        bus.pot_wr_data = '0;
        bus.wgt_wr_en   = 1'b0;
        bus.set_adder   = 1'b0;
        bus.clear_adder = 1'b0;
        bus.spike_valid = 1'b0;
        bus.spike_id    = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StClr;
                    scnt_d  = '0;
                    idx_d   = '0;
                end
            end
            StClr: begin
                bus.clear_adder = 1'b1;
                state_d         = StSet;
            end
            StSet: begin
                bus.set_adder = 1'b1;
                state_d       = StRd;
            end
            StRd: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = idx_q;
                cnt_d         = '0;
                state_d       = StEval;
`ifdef SCHED_SKIP_ZERO_EN
                skip_d        = 1'b0;
`endif
            end
            StEval: begin
                cnt_d = cnt_q + 1'b1;
                // Memory read data is only valid in the first EVAL cycle.
                if (cnt_q == '0) begin
                    pot_d = bus.pot_rd_data;
                    wgt_d = bus.wgt_rd_data;
`ifdef SCHED_SKIP_ZERO_EN
                    if (bus.wgt_rd_data[30:0] == '0) begin
                        skip_d  = 1'b1;
                        state_d = StWb;
                    end
`endif
                end
                if (cnt_q == LastCnt) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                bus.pot_wr_en = 1'b1;
                bus.wgt_wr_en = 1'b1;
                bus.mem_addr  = idx_q;
`ifdef SCHED_SKIP_ZERO_EN
                bus.pot_wr_data = skip_q ? pot_q : bus.adder_final;
                wb_spike        = bus.adder_spike & ~skip_q;
`else
                bus.pot_wr_data = bus.adder_final;
                wb_spike        = bus.adder_spike;
`endif
                if (wb_spike) begin
                    state_d = StSpk;
                    if (scnt_q != '1) begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            StSpk: begin
                bus.spike_valid = 1'b1;
                bus.spike_id    = idx_q;
                advance         = bus.spike_ready;
            end
            StFin: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Next-neuron step shares the WB/SPK cycle instead of costing its own.
        if (advance) begin
            if (idx_q == LastIdx) begin
                state_d = StFin;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = StRd;
            end
        end
    end

    assign bus.busy            = (state_q != StIdle) && (state_q != StFin);
    assign bus.adder_weight    = wgt_q;
    assign bus.adder_potential = pot_q;
    assign bus.spike_count     = scnt_q;
endmodule

// File: tb/tb_lif_update_scheduler.sv
// Directed bench for lif_update_scheduler with a memory model, an adder stub and
// write/spike scoreboards.
module tb_lif_update_scheduler;
    localparam int unsigned N   = 30;
    localparam int unsigned IW  = 5;
    localparam int unsigned LAT = 2;
    localparam int          BaseCycles = 2 + N * (LAT + 2);

    typedef struct packed {
        logic [IW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   valid_cycles = 0;
    int   cyc;
    int   n;
    int   v0;
    logic done_seen;

    logic [31:0]   pot_mem [32];
    logic [31:0]   wgt_mem [32];
    wr_t           wr_q [$];
    logic [IW-1:0] spk_q [$];
    wr_t           mon_e;
    logic [IW-1:0] mon_id;

    always #5 clk = ~clk;

    lif_update_scheduler_if #(.IDX_W(IW)) bus ();

    lif_update_scheduler #(
        .NUM_NEURONS(N),
        .IDX_W      (IW),
        .ADDER_LAT  (LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Adder stub: one specific operand pair gives the documented result, weights 0x7xxxxxxx spike.
    function automatic logic [31:0] stub_final(input logic [31:0] p, input logic [31:0] w);
        if (p == 32'h425ED852 && w == 32'h42470A3D) return 32'h4282F0A4;
        return p + w;
    endfunction

    function automatic logic stub_spike(input logic [31:0] p, input logic [31:0] w);
        return (p == 32'h425ED852 && w == 32'h42470A3D) || (w[31:28] == 4'h7);
    endfunction

    function automatic logic [31:0] exp_final(input logic [31:0] p, input logic [31:0] w);
`ifdef SCHED_SKIP_ZERO_EN
        if (w[30:0] == 31'd0) return p;
`endif
        return stub_final(p, w);
    endfunction

    function automatic logic exp_spike(input logic [31:0] p, input logic [31:0] w);
`ifdef SCHED_SKIP_ZERO_EN
        if (w[30:0] == 31'd0) return 1'b0;
`endif
        return stub_spike(p, w);
    endfunction

    always_comb begin
        bus.adder_final = stub_final(bus.adder_potential, bus.adder_weight);
        bus.adder_spike = stub_spike(bus.adder_potential, bus.adder_weight);
    end

    // Potential/weight memories: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.pot_rd_data <= pot_mem[bus.mem_addr];
            bus.wgt_rd_data <= wgt_mem[bus.mem_addr];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pot_wr_en || bus.wgt_wr_en) begin
                check("wgt_clr_with_pot", bus.wgt_wr_en, bus.pot_wr_en);
            end
            if (bus.pot_wr_en) begin
                check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
                if (wr_q.size() != 0) begin
                    mon_e = wr_q.pop_front();
                    check("wr_addr", bus.mem_addr, mon_e.addr);
                    check("wr_data", bus.pot_wr_data, mon_e.data);
                end
            end
            if (bus.spike_valid) valid_cycles++;
        end
    end

    // Handshake sampled on the same edge the DUT uses.
    always @(posedge clk) begin
        if (rst_n && bus.spike_valid && bus.spike_ready) begin
            check("spk_expected", 64'(spk_q.size() != 0), 64'd1);
            if (spk_q.size() != 0) begin
                mon_id = spk_q.pop_front();
                check("spike_id", bus.spike_id, mon_id);
            end
        end
    end

    task automatic init_mem();
        for (int i = 0; i < 32; i++) begin
            pot_mem[i] = 32'h3F000000 + 32'(i * 16);
            wgt_mem[i] = 32'h00001000 + 32'(i);
        end
    endtask

    task automatic prime();
        for (int i = 0; i < int'(N); i++) begin
            wr_t e;
            e.addr = IW'(i);
            e.data = exp_final(pot_mem[i], wgt_mem[i]);
            wr_q.push_back(e);
            if (exp_spike(pot_mem[i], wgt_mem[i])) spk_q.push_back(IW'(i));
        end
    endtask

    // Returns the number of cycles from the CLR cycle (0) to the cycle showing done.
    task automatic run_sweep(output int cycles);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_in_clr", bus.busy, 1'b1);
        check("clear_adder", bus.clear_adder, 1'b1);
        cycles = 0;
        while (!bus.done && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
        check("done_busy_low", bus.busy, 1'b0);
    endtask

    task automatic end_checks(input int cycles, input int exp_cycles, input int exp_spikes);
        check("sweep_cycles", 64'(cycles), 64'(exp_cycles));
        @(negedge clk);
        check("wr_q_drained", 64'(wr_q.size()), 64'd0);
        check("spk_q_drained", 64'(spk_q.size()), 64'd0);
        check("spike_count", bus.spike_count, 64'(exp_spikes));
        check("idle_after_done", {bus.busy, bus.done}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = 1'b0;
        bus.spike_ready = 1'b1;
        init_mem();
        repeat (3) @(negedge clk);
        check("reset_outs", {bus.busy, bus.done, bus.mem_rd_en, bus.pot_wr_en, bus.wgt_wr_en,
                             bus.spike_valid, bus.spike_count}, 0);
        rst_n = 1'b1;

        // Idle after reset release
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outs", {bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr, bus.pot_wr_en,
                                bus.pot_wr_data, bus.wgt_wr_en, bus.set_adder, bus.clear_adder,
                                bus.spike_valid, bus.spike_id, bus.spike_count}, 0);
        end
        check("idle_operands", {bus.adder_weight, bus.adder_potential}, 0);

        // No-spike sweep
        init_mem();
        prime();
        v0 = valid_cycles;
        run_sweep(cyc);
        end_checks(cyc, BaseCycles, 0);
        check("nospike_valid_cycles", 64'(valid_cycles - v0), 64'd0);

        // Single spike at neuron 7, consumer always ready
        init_mem();
        pot_mem[7] = 32'h425ED852;
        wgt_mem[7] = 32'h42470A3D;
        prime();
        v0 = valid_cycles;
        run_sweep(cyc);
        end_checks(cyc, BaseCycles + 1, 1);
        check("single_valid_cycles", 64'(valid_cycles - v0), 64'd1);

        // Back-to-back spikes at 3 and 4 with a 10-cycle stall on the first
        init_mem();
        wgt_mem[3] = 32'h70000003;
        wgt_mem[4] = 32'h70000004;
        prime();
        bus.spike_ready = 1'b0;
        fork
            run_sweep(cyc);
            begin
                n = 0;
                while (!bus.spike_valid && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 10; i++) begin
                    check("stall_hold", {bus.spike_valid, bus.spike_id, bus.pot_wr_en,
                                         bus.wgt_wr_en, bus.mem_rd_en}, {1'b1, 5'd3, 3'b000});
                    @(negedge clk);
                end
                bus.spike_ready = 1'b1;
            end
        join
        end_checks(cyc, BaseCycles + 11 + 1, 2);

        // Zero weight (-0) at neuron 2
        init_mem();
        wgt_mem[2] = 32'h80000000;
        prime();
        run_sweep(cyc);
`ifdef SCHED_SKIP_ZERO_EN
        end_checks(cyc, BaseCycles - (LAT - 1), 0);
`else
        end_checks(cyc, BaseCycles, 0);
`endif

        // Start while busy is ignored; reset mid-sweep aborts without done
        init_mem();
        prime();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!(bus.mem_rd_en && bus.mem_addr == 5'd5) && n < 500) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_2nd_start", bus.busy, 1'b1);
        n = 0;
        while (!bus.mem_rd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rd_after_ignored_start", bus.mem_addr, 5'd6);
        n = 0;
        while (!(bus.mem_rd_en && bus.mem_addr == 5'd12) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_neuron12", {bus.mem_rd_en, bus.mem_addr}, {1'b1, 5'd12});
        rst_n = 1'b0;
        #1;
        check("abort_outs", {bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr, bus.pot_wr_en,
                             bus.wgt_wr_en, bus.spike_valid, bus.spike_count}, 0);
        check("abort_operands", {bus.adder_weight, bus.adder_potential}, 0);
        done_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            done_seen = done_seen | bus.done;
        end
        check("no_done_in_reset", done_seen, 1'b0);
        rst_n = 1'b1;
        wr_q.delete();
        spk_q.delete();
        @(negedge clk);
        prime();
        run_sweep(cyc);
        end_checks(cyc, BaseCycles, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
